// File: rtl/csc_pkg.sv
// Shared types and constants for the RGB-to-luma conversion stage and
// the raster position helpers it uses.
package csc_pkg;

    // One RGB888 pixel as it arrives on data_m: {R, G, B}.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // 8-bit luma sample.
    typedef logic [7:0] luma_t;

    // Rounding constant added before dropping the Q0.8 fraction.
    localparam int LUMA_ROUND = 128;
    localparam int LUMA_SHIFT = 8;

    // Default BT.601-style weights in Q0.8; they sum to 256.
    localparam int DEF_COEF_R = 77;
    localparam int DEF_COEF_G = 150;
    localparam int DEF_COEF_B = 29;

    // Default raster geometry.
    localparam int DEF_IMAGE_WIDTH  = 1920;
    localparam int DEF_IMAGE_HEIGHT = 1080;

    // Counter width for a range of n values; never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rgb2y_csc_raster_pos_cnt.sv
// raster_pos_cnt: x/y raster position counters with end-of-line and
// end-of-frame wrap. sof/eol describe the position the next advance
// consumes, so a caller samples them together with its advance enable.
module raster_pos_cnt
    import csc_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    localparam int XW = cnt_width(IMAGE_WIDTH),
    localparam int YW = cnt_width(IMAGE_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_adv,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_sof,
    output logic          o_eol
);

    localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          w_x_last;
    logic          w_y_last;

    assign w_x_last = (r_x == X_LAST);
    assign w_y_last = (r_y == Y_LAST);

    assign o_x   = r_x;
    assign o_y   = r_y;
    assign o_sof = (r_x == '0) && (r_y == '0);
    assign o_eol = w_x_last;

    // Step the position on each advance; wrap x per line and y per frame
    // so consecutive frames follow each other without a gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_adv) begin
            if (w_x_last) begin
                r_x <= '0;
                if (w_y_last) begin
                    r_y <= '0;
                end else begin
                    r_y <= r_y + 1'b1;
                end
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rgb2y_csc.sv
// rgb2y_csc: RGB888 to 8-bit luma conversion feeding the Sobel line
// buffers. Three-stage pipeline (multiply, sum+round, truncate) that
// stalls as a whole when the output is held. sof/eol are computed at
// acceptance and travel with each pixel.
// Optional build macro CSC_DBG_RGB_EN adds dbg_rgb_s, the original RGB
// of the pixel currently on data_s.
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both high. ready_m is combinational (~valid_s | ready_s); while
// valid_s is high and ready_s low, data_s/sof_s/eol_s are held.
module rgb2y_csc
    import csc_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int COEF_R       = DEF_COEF_R,
    parameter int COEF_G       = DEF_COEF_G,
    parameter int COEF_B       = DEF_COEF_B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] data_m,
    input  logic        valid_m,
    output logic        ready_m,
    output logic [7:0]  data_s,
    output logic        valid_s,
    input  logic        ready_s,
    output logic        sof_s,
    output logic        eol_s
`ifdef CSC_DBG_RGB_EN
    ,
    output logic [23:0] dbg_rgb_s
`endif
);

    localparam int XW = cnt_width(IMAGE_WIDTH);
    localparam int YW = cnt_width(IMAGE_HEIGHT);

    rgb888_t       w_pix;
    logic          w_adv;
    logic          w_acc;
    logic          w_sof;
    logic          w_eol;
    logic [XW-1:0] w_x_unused;
    logic [YW-1:0] w_y_unused;
    logic          w_sum_unused;

    // Stage 1: weighted products.
    logic          r_v1;
    logic [15:0]   r_pr;
    logic [15:0]   r_pg;
    logic [15:0]   r_pb;
    logic          r_sof1;
    logic          r_eol1;

    // Stage 2: rounded sum.
    logic          r_v2;
    logic [16:0]   r_sum;
    logic          r_sof2;
    logic          r_eol2;

    // Stage 3: output register.
    logic          r_v3;
    luma_t         r_y;
    logic          r_sof3;
    logic          r_eol3;

    assign w_pix   = data_m;
    // The whole pipe moves when the output slot is empty or being taken.
    assign w_adv   = ~r_v3 | ready_s;
    assign ready_m = w_adv;
    assign w_acc   = valid_m & w_adv;

    raster_pos_cnt #(
        .IMAGE_WIDTH  (IMAGE_WIDTH),
        .IMAGE_HEIGHT (IMAGE_HEIGHT)
    ) u_pos (
        .clk   (clk),
        .rst   (rst),
        .i_adv (w_acc),
        .o_x   (w_x_unused),
        .o_y   (w_y_unused),
        .o_sof (w_sof),
        .o_eol (w_eol)
    );

    // Stage 1: multiply each channel by its weight; markers are gated
    // with valid so a bubble never carries a stray sof/eol.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_pr   <= '0;
            r_pg   <= '0;
            r_pb   <= '0;
            r_sof1 <= 1'b0;
            r_eol1 <= 1'b0;
        end else if (w_adv) begin
            r_v1   <= valid_m;
            r_pr   <= 16'(w_pix.r) * 16'(COEF_R);
            r_pg   <= 16'(w_pix.g) * 16'(COEF_G);
            r_pb   <= 16'(w_pix.b) * 16'(COEF_B);
            r_sof1 <= valid_m & w_sof;
            r_eol1 <= valid_m & w_eol;
        end
    end

    // Stage 2: sum the products plus half an LSB for round-to-nearest.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2   <= 1'b0;
            r_sum  <= '0;
            r_sof2 <= 1'b0;
            r_eol2 <= 1'b0;
        end else if (w_adv) begin
            r_v2   <= r_v1;
            r_sum  <= 17'(r_pr) + 17'(r_pg) + 17'(r_pb) + 17'(LUMA_ROUND);
            r_sof2 <= r_sof1;
            r_eol2 <= r_eol1;
        end
    end

    // Stage 3: drop the fraction. Weights sum to 256 so the sum tops out
    // at 65408 and bit 16 can never be set; no saturation needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v3   <= 1'b0;
            r_y    <= '0;
            r_sof3 <= 1'b0;
            r_eol3 <= 1'b0;
        end else if (w_adv) begin
            r_v3   <= r_v2;
            r_y    <= r_sum[LUMA_SHIFT +: 8];
            r_sof3 <= r_sof2;
            r_eol3 <= r_eol2;
        end
    end

    assign w_sum_unused = ^{r_sum[16], r_sum[LUMA_SHIFT-1:0]};

    assign data_s  = r_y;
    assign valid_s = r_v3;
    assign sof_s   = r_sof3;
    assign eol_s   = r_eol3;

`ifdef CSC_DBG_RGB_EN
    logic [23:0] r_rgb1;
    logic [23:0] r_rgb2;
    logic [23:0] r_rgb3;

    // Carry the source RGB alongside the luma through the same stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb1 <= '0;
            r_rgb2 <= '0;
            r_rgb3 <= '0;
        end else if (w_adv) begin
            r_rgb1 <= data_m;
            r_rgb2 <= r_rgb1;
            r_rgb3 <= r_rgb2;
        end
    end

    assign dbg_rgb_s = r_rgb3;
`endif

endmodule
